// File: rtl/move_encoder_if.sv
// Button/movement bus between the board buttons and move_encoder.
// slave is the encoder side; master is whatever drives the buttons.
interface move_encoder_if;
    logic [4:0] bt;
    logic [2:0] dmov;
    logic       step;
    logic [4:0] btdb;

    modport master (output bt, input dmov, step, btdb);
    modport slave  (input bt, output dmov, step, btdb);
endinterface

// File: rtl/move_encoder.sv
// Push-button conditioning for vgacontroller: sync + debounce, priority encode to dmov, step strobe.
// Optional build macro MOVE_AUTOREPEAT_EN adds timed auto-repeat of step while a move is held.

module move_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk25m,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam logic [23:0] DB_M1 = 24'(DB_CYCLES - 1);

    logic        s1, s2;
    logic [23:0] cnt;

    always_ff @(posedge clk25m or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            // counter only advances while the input disagrees with the accepted level
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == DB_M1) begin
                dout <= ~dout;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 24'd1;
            end
        end
    end
endmodule

module move_encoder #(
    parameter int DB_CYCLES  = 250000,
    parameter int REP_DELAY  = 12500000,
    parameter int REP_PERIOD = 2500000
) (
    input  logic          clk25m,
    input  logic          rst,
    move_encoder_if.slave bus
);
    localparam int NUM_BTN = 5;
    localparam logic [2:0] C_IDLE  = 3'b000;
    localparam logic [2:0] C_UP    = 3'b001;
    localparam logic [2:0] C_DOWN  = 3'b010;
    localparam logic [2:0] C_LEFT  = 3'b011;
    localparam logic [2:0] C_RIGHT = 3'b100;
    localparam logic [2:0] C_FIRE  = 3'b101;

`ifdef MOVE_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} st_t;
    localparam logic [23:0] RD_M1 = 24'(REP_DELAY - 1);
    localparam logic [23:0] RP_M1 = 24'(REP_PERIOD - 1);
    logic [23:0] timer, ntimer;
`else
    typedef enum logic [1:0] {IDLE, DELAY} st_t;
`endif

    st_t                state, nstate;
    logic [NUM_BTN-1:0] btdb;
    logic [2:0]         code;
    logic [2:0]         dmov_r;
    logic               step_r;
    logic               pulse;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        move_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk25m (clk25m),
            .rst    (rst),
            .din    (bus.bt[i]),
            .dout   (btdb[i])
        );
    end

    always_comb begin
        code = C_IDLE;
        if      (btdb[4]) code = C_FIRE;
        else if (btdb[0]) code = C_UP;
        else if (btdb[1]) code = C_DOWN;
        else if (btdb[2]) code = C_LEFT;
        else if (btdb[3]) code = C_RIGHT;
    end

    // dmov_r holds last cycle's code, so code != dmov_r marks a change
    always_comb begin
        nstate = state;
        pulse  = 1'b0;
`ifdef MOVE_AUTOREPEAT_EN
        ntimer = timer;
`endif
        if (code == C_IDLE) begin
            nstate = IDLE;
`ifdef MOVE_AUTOREPEAT_EN
            ntimer = '0;
`endif
        end else if (state == IDLE || code != dmov_r) begin
            pulse  = 1'b1;
            nstate = DELAY;
`ifdef MOVE_AUTOREPEAT_EN
            ntimer = '0;
`endif
        end else begin
`ifdef MOVE_AUTOREPEAT_EN
            case (state)
                DELAY: begin
                    // fire parks here with the timer frozen
                    if (code != C_FIRE) begin
                        if (timer == RD_M1) begin
                            pulse  = 1'b1;
                            nstate = REPEAT;
                            ntimer = '0;
                        end else begin
                            ntimer = timer + 24'd1;
                        end
                    end
                end
                REPEAT: begin
                    if (timer == RP_M1) begin
                        pulse  = 1'b1;
                        ntimer = '0;
                    end else begin
                        ntimer = timer + 24'd1;
                    end
                end
                default: nstate = IDLE;
            endcase
`endif
        end
    end

    always_ff @(posedge clk25m or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            dmov_r <= C_IDLE;
            step_r <= 1'b0;
`ifdef MOVE_AUTOREPEAT_EN
            timer  <= '0;
`endif
        end else begin
            state  <= nstate;
            dmov_r <= code;
            step_r <= pulse;
`ifdef MOVE_AUTOREPEAT_EN
            timer  <= ntimer;
`endif
        end
    end

    assign bus.dmov = dmov_r;
    assign bus.step = step_r;
    assign bus.btdb = btdb;
endmodule

// File: tb/tb_move_encoder.sv
// Randomised + directed bench for move_encoder against a window/age-based reference model.
module tb_move_encoder;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef MOVE_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk25m = 1'b0;
    logic rst    = 1'b1;
    always #5 clk25m = ~clk25m;

    move_encoder_if bus();

    move_encoder #(.DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
        .clk25m (clk25m),
        .rst    (rst),
        .bus    (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;
    int nsteps = 0;
    int step_log[$];
    int exp_log[$];

    // reference model state
    logic [4:0] q1, q2, acc;
    logic [4:0] win[$];
    logic [2:0] m_dmov;
    logic       m_step;
    int         age;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    function automatic logic [2:0] prio(input logic [4:0] b);
        if (b[4]) return 3'd5;
        if (b[0]) return 3'd1;
        if (b[1]) return 3'd2;
        if (b[2]) return 3'd3;
        if (b[3]) return 3'd4;
        return 3'd0;
    endfunction

    task automatic model_reset();
        q1 = '0; q2 = '0; acc = '0;
        win.delete();
        m_dmov = '0; m_step = 1'b0; age = 0;
    endtask

    // A level is accepted once the last DB synchronised samples all disagree with it;
    // step fires on a new nonzero move, and (auto-repeat) at age RD, RD+RP, ...
    task automatic model_edge(input logic [4:0] b);
        logic [4:0] din, nacc;
        logic [2:0] nd;
        bit all_diff;
        din = q2; q2 = q1; q1 = b;
        win.push_back(din);
        if (win.size() > DB) void'(win.pop_front());
        nd = prio(acc);
        nacc = acc;
        if (win.size() == DB) begin
            for (int i = 0; i < 5; i++) begin
                all_diff = 1'b1;
                foreach (win[k]) if (win[k][i] == acc[i]) all_diff = 1'b0;
                if (all_diff) nacc[i] = ~acc[i];
            end
        end
        age = (nd != m_dmov) ? 0 : age + 1;
        m_step = (nd != 3'd0) &&
                 ((nd != m_dmov) || (AR && nd != 3'd5 && age >= RD && ((age - RD) % RP) == 0));
        m_dmov = nd;
        acc = nacc;
    endtask

    task automatic cyc(input logic [4:0] b);
        bus.bt = b;
        @(posedge clk25m);
        if (rst) model_reset();
        else     model_edge(b);
        @(negedge clk25m);
        cyc_n++;
        chk("dmov", 32'(bus.dmov), 32'(m_dmov));
        chk("step", 32'(bus.step), 32'(m_step));
        chk("btdb", 32'(bus.btdb), 32'(acc));
        if (bus.step) begin
            nsteps++;
            step_log.push_back(cyc_n);
        end
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_cnt"}, 32'(step_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < step_log.size(); i++)
            chk({tag, "_at"}, 32'(step_log[i]), 32'(exp_log[i]));
    endtask

    initial begin
        int base, len, t;
        logic [4:0] b;
        bus.bt = '0;
        model_reset();
        repeat (2) @(negedge clk25m);
        chk("rst_dmov", 32'(bus.dmov), 32'd0);
        chk("rst_step", 32'(bus.step), 32'd0);
        chk("rst_btdb", 32'(bus.btdb), 32'd0);
        rst = 1'b0;

        // reset while up is held, then re-debounce
        repeat (10) cyc(5'b00001);
        chk("pre_rst_dmov", 32'(bus.dmov), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_dmov", 32'(bus.dmov), 32'd0);
        chk("async_step", 32'(bus.step), 32'd0);
        chk("async_btdb", 32'(bus.btdb), 32'd0);
        repeat (3) cyc(5'b00001);
        rst = 1'b0;
        step_log.delete(); exp_log.delete();
        base = cyc_n;
        repeat (6) cyc(5'b00001);
        chk("first_dmov_early", 32'(bus.dmov), 32'd0);
        repeat (94) cyc(5'b00001);
        exp_log.push_back(base + 7);
        if (AR) for (t = base + 7 + RD; t <= base + 100; t += RP) exp_log.push_back(t);
        chk_log("held_up");
        chk("held_dmov", 32'(bus.dmov), 32'd1);

        // bounce rejection on down
        repeat (10) cyc(5'b00000);
        nsteps = 0;
        repeat (10) begin
            repeat (2) cyc(5'b00010);
            repeat (2) cyc(5'b00000);
        end
        chk("bounce_steps", 32'(nsteps), 32'd0);
        chk("bounce_btdb", 32'(bus.btdb), 32'd0);
        chk("bounce_dmov", 32'(bus.dmov), 32'd0);

        // right, then fire added on top
        repeat (20) cyc(5'b01000);
        chk("right_dmov", 32'(bus.dmov), 32'd4);
        step_log.delete(); exp_log.delete();
        base = cyc_n;
        repeat (100) cyc(5'b11000);
        exp_log.push_back(base + 7);
        chk_log("fire");
        chk("fire_dmov", 32'(bus.dmov), 32'd5);

        // release everything
        step_log.delete(); exp_log.delete();
        repeat (6) cyc(5'b00000);
        chk("rel_dmov_hold", 32'(bus.dmov), 32'd5);
        cyc(5'b00000);
        chk("rel_dmov", 32'(bus.dmov), 32'd0);
        chk_log("release");

        // random holds, glitches and occasional resets
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 1) == 0) b = 5'(1 << $urandom_range(0, 4));
            else                           b = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) b = '0;
            len = $urandom_range(1, 45);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 15) == 0) cyc(b ^ 5'(1 << $urandom_range(0, 4)));
                else                            cyc(b);
            end
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) cyc(b);
                rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
